ins_prefetch: RTL

Instruction fetch stage placed between a variable-latency instruction memory and the single-cycle core's instruction port. It issues sequential word fetches over a req/ack handshake and buffers the returned instructions, with their PCs, in a small FIFO. The core pops instructions with a valid/ready handshake. A branch redirect flushes the buffer and restarts fetching at the new PC, and the response of any request already in flight is discarded.

---
 rtl/ins_prefetch_if.sv | 24 ++
 rtl/ins_prefetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/ins_prefetch_if.sv
// Bundle of core-side instruction port and memory-side fetch port of the prefetch stage.
// master is the prefetcher's view; slave is the view of the core plus instruction memory.
interface ins_prefetch_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ins_ready;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  flush, flush_pc, ins_ready, mem_ack, mem_rdata,
    output ins_valid, ins, ins_pc, mem_req, mem_addr
  );

  modport slave (
    output flush, flush_pc, ins_ready, mem_ack, mem_rdata,
    input  ins_valid, ins, ins_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/ins_prefetch.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch into a small {pc, ins} FIFO,
// with redirect flush that empties the buffer and discards any in-flight response.
module ins_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk_i,
  input logic            rst_ni,
  ins_prefetch_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     stale_addr_q, stale_addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem_q  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];
  logic            push, pop;

  assign pop  = (count_q != '0) && bus.ins_ready && !bus.flush;
  assign push = (state_q == StWait) && bus.mem_ack && !bus.flush;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (bus.flush) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = {bus.flush_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.flush || (count_d < CntFull)) state_d = StWait;
      end
      StWait: begin
        if (bus.flush) begin
          // The old request is still in flight: keep presenting its address until it is acked.
          if (!bus.mem_ack) begin
            state_d      = StDiscard;
            stale_addr_d = fetch_pc_q;
          end
        end else if (bus.mem_ack && (count_d == CntFull)) begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (bus.mem_ack) state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
      ins_mem_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end

  assign bus.ins_valid = (count_q != '0);
  assign bus.ins       = ins_mem_q[rd_ptr_q];
  assign bus.ins_pc    = pc_mem_q[rd_ptr_q];
  assign bus.mem_req   = (state_q != StIdle);
  assign bus.mem_addr  = (state_q == StDiscard) ? stale_addr_q : fetch_pc_q;

endmodule
